// File: rtl/tank_state_uart_tx.sv
// Snapshots the local tank state on each vsync rise and sends it as an 8N1 UART packet.
// Optional checksum byte (XOR of bytes 1..3) is enabled by defining TANK_TX_CHECKSUM_EN.
module tank_state_uart_tx #(
   parameter int          CLKS_PER_BIT = 564,
   parameter logic [7:0]  HEADER       = 8'hA5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       vsync,
   input  logic [9:0] pos_x,
   input  logic [9:0] pos_y,
   input  logic [1:0] direction_tank,
   output logic       tx,
   output logic       busy,
   output logic       overrun
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } state_t;

   localparam logic [11:0] BIT_LAST = 12'(CLKS_PER_BIT - 1);
`ifdef TANK_TX_CHECKSUM_EN
   localparam logic [2:0] LAST_BYTE = 3'd4;
`else
   localparam logic [2:0] LAST_BYTE = 3'd3;
`endif

`ifdef TANK_TX_CHECKSUM_EN
   function automatic logic [7:0] xor_checksum(input logic [7:0] b1,
                                               input logic [7:0] b2,
                                               input logic [7:0] b3);
      return b1 ^ b2 ^ b3;
   endfunction
`endif

   function automatic logic [7:0] packet_byte(input logic [2:0] idx,
                                              input logic [9:0] x,
                                              input logic [9:0] y,
                                              input logic [1:0] dir);
      logic [7:0] b3;
      b3 = {2'b00, dir, y[9:8], x[9:8]};
      case (idx)
         3'd0:    packet_byte = HEADER;
         3'd1:    packet_byte = x[7:0];
         3'd2:    packet_byte = y[7:0];
         3'd3:    packet_byte = b3;
`ifdef TANK_TX_CHECKSUM_EN
         3'd4:    packet_byte = xor_checksum(x[7:0], y[7:0], b3);
`endif
         default: packet_byte = 8'hFF;
      endcase
   endfunction

   state_t      state_r, state_next_s;
   logic        vsync_q_r;
   logic        req_s;
   logic        bit_done_s;
   logic [11:0] timer_r, timer_next_s;
   logic [2:0]  bit_idx_r, bit_idx_next_s;
   logic [2:0]  byte_idx_r, byte_idx_next_s;
   logic [9:0]  snap_x_r, snap_y_r;
   logic [1:0]  snap_dir_r;
   logic        snap_load_s;
   logic [7:0]  cur_byte_s;
   logic        tx_r, tx_next_s;
   logic        busy_r, busy_next_s;
   logic        overrun_r, overrun_next_s;

   assign req_s       = vsync & ~vsync_q_r;
   assign bit_done_s  = (timer_r == BIT_LAST);
   assign snap_load_s = (state_r == ST_IDLE) & req_s;

   // State, counters, edge detector and snapshot registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r    <= ST_IDLE;
         vsync_q_r  <= 1'b0;
         timer_r    <= 12'd0;
         bit_idx_r  <= 3'd0;
         byte_idx_r <= 3'd0;
         snap_x_r   <= 10'd0;
         snap_y_r   <= 10'd0;
         snap_dir_r <= 2'd0;
      end else begin
         state_r    <= state_next_s;
         vsync_q_r  <= vsync;
         timer_r    <= timer_next_s;
         bit_idx_r  <= bit_idx_next_s;
         byte_idx_r <= byte_idx_next_s;
         if (snap_load_s) begin
            snap_x_r   <= pos_x;
            snap_y_r   <= pos_y;
            snap_dir_r <= direction_tank;
         end
      end
   end

   // Next-state logic
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (req_s) state_next_s = ST_START;
            else       state_next_s = ST_IDLE;
         end
         ST_START: begin
            if (bit_done_s) state_next_s = ST_DATA;
            else            state_next_s = ST_START;
         end
         ST_DATA: begin
            if (bit_done_s && (bit_idx_r == 3'd7)) state_next_s = ST_STOP;
            else                                   state_next_s = ST_DATA;
         end
         ST_STOP: begin
            if (!bit_done_s)                    state_next_s = ST_STOP;
            else if (byte_idx_r == LAST_BYTE)   state_next_s = ST_IDLE;
            else                                state_next_s = ST_START;
         end
         default: state_next_s = ST_IDLE;
      endcase
   end

   // Bit timer, bit index and byte index updates
   always_comb begin
      timer_next_s    = 12'd0;
      bit_idx_next_s  = bit_idx_r;
      byte_idx_next_s = byte_idx_r;

      if (state_r == ST_IDLE)  timer_next_s = 12'd0;
      else if (bit_done_s)     timer_next_s = 12'd0;
      else                     timer_next_s = timer_r + 12'd1;

      if ((state_next_s == ST_START) && (state_r != ST_START))
         bit_idx_next_s = 3'd0;
      else if ((state_r == ST_DATA) && bit_done_s)
         bit_idx_next_s = bit_idx_r + 3'd1;
      else
         bit_idx_next_s = bit_idx_r;

      if (snap_load_s)
         byte_idx_next_s = 3'd0;
      else if ((state_r == ST_STOP) && bit_done_s && (byte_idx_r != LAST_BYTE))
         byte_idx_next_s = byte_idx_r + 3'd1;
      else
         byte_idx_next_s = byte_idx_r;
   end

   // Output decode from the upcoming state so tx/busy change on the same edge as the state
   always_comb begin
      cur_byte_s     = packet_byte(byte_idx_next_s, snap_x_r, snap_y_r, snap_dir_r);
      tx_next_s      = 1'b1;
      case (state_next_s)
         ST_IDLE:  tx_next_s = 1'b1;
         ST_START: tx_next_s = 1'b0;
         ST_DATA:  tx_next_s = cur_byte_s[bit_idx_next_s];
         ST_STOP:  tx_next_s = 1'b1;
         default:  tx_next_s = 1'b1;
      endcase
      busy_next_s    = (state_next_s != ST_IDLE);
      overrun_next_s = overrun_r | (req_s & (state_r != ST_IDLE));
   end

   // Registered outputs
   always_ff @(posedge clk) begin
      if (!rst) begin
         tx_r      <= 1'b1;
         busy_r    <= 1'b0;
         overrun_r <= 1'b0;
      end else begin
         tx_r      <= tx_next_s;
         busy_r    <= busy_next_s;
         overrun_r <= overrun_next_s;
      end
   end

   assign tx      = tx_r;
   assign busy    = busy_r;
   assign overrun = overrun_r;

endmodule
